phase_sequencer: RTL

//  Generates the 3-bit instruction phase for the CPU controller and the datapath clock enable.

---
 rtl/phase_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Instruction phase generator and run/stop/step/breakpoint controller for the CPU controller.
// Registered outputs except cpu_en, which is combinational so a breakpoint freezes the datapath in the same cycle.
module phase_sequencer #(
    parameter int AWIDTH = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              stop_req,
    input  logic              halt,
    input  logic [AWIDTH-1:0] pc_addr,
    input  logic [AWIDTH-1:0] bp_addr,
    input  logic              bp_valid,
    output logic [2:0]        phase,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic              stopped,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  instr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic               bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stop_pending_q, stop_pending_d;
    logic               resume_q, resume_d;

    logic bp_stop;
    logic active;
    logic wrap;
    logic halt_ev;

    // resume masks the breakpoint we just stopped on until the first phase advance
    assign bp_stop = bp_valid && (pc_addr == bp_addr) && (phase_q == 3'd0)
                     && (state_q == ST_RUN) && !resume_q;
    assign active  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign cpu_en  = active && !bp_stop;
    assign wrap    = cpu_en && (phase_q == 3'd7);
    assign halt_ev = cpu_en && (phase_q == 3'd4) && halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= 3'd0;
            bp_hit_q       <= 1'b0;
            cnt_q          <= '0;
            stop_pending_q <= 1'b0;
            resume_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            bp_hit_q       <= bp_hit_d;
            cnt_q          <= cnt_d;
            stop_pending_q <= stop_pending_d;
            resume_q       <= resume_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        bp_hit_d       = 1'b0;
        cnt_d          = cnt_q;
        stop_pending_d = stop_pending_q;
        resume_d       = resume_q;

        if (cpu_en) begin
            phase_d  = phase_q + 3'd1;
            resume_d = 1'b0;
        end
        if (wrap) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        unique case (state_q)
            ST_IDLE: begin
                phase_d = 3'd0;
                if (step_req) begin
                    state_d  = ST_STEP;
                    resume_d = 1'b1;
                end else if (run_req) begin
                    state_d  = ST_RUN;
                    resume_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (bp_stop) begin
                    state_d        = ST_IDLE;
                    bp_hit_d       = 1'b1;
                    stop_pending_d = 1'b0;
                end else if (halt_ev) begin
                    state_d        = ST_HALTED;
                    stop_pending_d = 1'b0;
                end else if (wrap && stop_pending_q) begin
                    state_d        = ST_IDLE;
                    stop_pending_d = 1'b0;
                end else if (stop_req) begin
                    stop_pending_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (halt_ev) begin
                    state_d = ST_HALTED;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase     = phase_q;
    assign state     = state_q;
    assign stopped   = (state_q == ST_IDLE) || (state_q == ST_HALTED);
    assign bp_hit    = bp_hit_q;
    assign instr_cnt = cnt_q;

endmodule
